// File: rtl/csr_timer_irq.sv
// CSR-mapped timer: prescaled 32-bit up-counter with compare match, one-shot or
// periodic mode, and a level-sensitive registered interrupt.
`timescale 1ns/1ps
module csr_timer_irq #(
    parameter logic [11:0] BASE_ADDR      = 12'hBC2,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        irq
);

    localparam int PW = PRESCALE_WIDTH;

    logic          ctrl_en;
    logic          ctrl_ie;
    logic          ctrl_per;
    logic          ctrl_pend;
    logic [PW-1:0] prescale;
    logic [PW-1:0] pcnt;
    logic [31:0]   count;
    logic [31:0]   compare;

    logic [11:0]   offset;
    logic [1:0]    sel;
    logic          sw_op;
    logic          sw_ctrl;
    logic          sw_pre;
    logic          sw_cnt;
    logic          sw_cmp;
    logic [31:0]   ctrl_rd;
    logic [31:0]   prescale_rd;
    logic [31:0]   ctrl_new;
    logic [31:0]   pre_new;
    logic [31:0]   cnt_new;
    logic [31:0]   cmp_new;
    logic          tick;
    logic          match;
    logic          unused_inputs;

    function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
        case (op)
            2'b01:   csr_apply = wd;
            2'b10:   csr_apply = old | wd;
            2'b11:   csr_apply = old & ~wd;
            default: csr_apply = old;
        endcase
    endfunction

    // Wrapping subtraction makes addresses below the base land far outside 0..3.
    assign offset = addr - BASE_ADDR;
    assign valid  = (offset < 12'd4);
    assign sel    = offset[1:0];

    assign sw_op   = valid && (modify[1:0] != 2'b00);
    assign sw_ctrl = sw_op && (sel == 2'd0);
    assign sw_pre  = sw_op && (sel == 2'd1);
    assign sw_cnt  = sw_op && (sel == 2'd2);
    assign sw_cmp  = sw_op && (sel == 2'd3);

    assign ctrl_rd = {28'd0, ctrl_pend, ctrl_per, ctrl_ie, ctrl_en};

    always_comb begin
        prescale_rd         = '0;
        prescale_rd[PW-1:0] = prescale;
    end

    assign ctrl_new = csr_apply(modify[1:0], ctrl_rd, wdata);
    assign pre_new  = csr_apply(modify[1:0], prescale_rd, wdata);
    assign cnt_new  = csr_apply(modify[1:0], count, wdata);
    assign cmp_new  = csr_apply(modify[1:0], compare, wdata);

    assign tick  = ctrl_en && (pcnt == prescale);
    assign match = tick && (count == compare);

    always_comb begin
        rdata = '0;
        if (valid) begin
            case (sel)
                2'd0:    rdata = ctrl_rd;
                2'd1:    rdata = prescale_rd;
                2'd2:    rdata = count;
                default: rdata = compare;
            endcase
        end
    end

    // Reads carry no side effects; the strobe and modify[2] are deliberately unused.
    assign unused_inputs = ^{read, modify[2], ctrl_new[31:4], pre_new};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_en   <= 1'b0;
            ctrl_ie   <= 1'b0;
            ctrl_per  <= 1'b0;
            ctrl_pend <= 1'b0;
            prescale  <= '0;
            pcnt      <= '0;
            count     <= '0;
            compare   <= 32'hFFFF_FFFF;
            irq       <= 1'b0;
        end else begin
            if (sw_pre) prescale <= pre_new[PW-1:0];
            if (sw_cmp) compare <= cmp_new;

            if (sw_pre || !ctrl_en || tick) pcnt <= '0;
            else                            pcnt <= pcnt + 1'b1;

            // A software COUNT op overrides the tick's increment or reload.
            if (sw_cnt)     count <= cnt_new;
            else if (match) count <= '0;
            else if (tick)  count <= count + 32'd1;

            if (sw_ctrl) begin
                ctrl_ie  <= ctrl_new[1];
                ctrl_per <= ctrl_new[2];
            end

            if (sw_ctrl)                  ctrl_en <= ctrl_new[0];
            else if (match && !ctrl_per) ctrl_en <= 1'b0;

            // Hardware match wins over a same-cycle software clear of PEND.
            if (match)        ctrl_pend <= 1'b1;
            else if (sw_ctrl) ctrl_pend <= ctrl_new[3];

            irq <= ctrl_pend & ctrl_ie;
        end
    end

endmodule

// File: doc/csr_timer_irq.md
CSR_TIMER_IRQ -- requirements
Module: csr_timer_irq

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'hBC2, first CSR address of a 4-register window.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 16, width of prescaler register and counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port read  input  1  CSR read strobe from pipeline.
REQ-006 SHALL have port modify  input  3  CSR op: [1:0] 00 none, 01 write, 10 set bits, 11 clear bits; [2] ignored.
REQ-007 SHALL have port wdata  input  32  CSR operand.
REQ-008 SHALL have port addr  input  12  CSR address.
REQ-009 SHALL have port rdata  output  32  selected register value, 0 when addr outside window.
REQ-010 SHALL have port valid  output  1  high when addr in window (combinational), for OR-bus merge.
REQ-011 SHALL have port irq  output  1  registered timer interrupt, feeds pipeline irq_timer.

Function
REQ-012 SHALL decode BASE+0 CTRL, BASE+1 PRESCALE, BASE+2 COUNT, BASE+3 COMPARE; unused bits read 0.
REQ-013 SHALL define CTRL bits: [0] EN, [1] IE, [2] PERIODIC, [3] PEND; other bits read 0, writes ignored.
REQ-014 SHALL compute new value = wdata (write), old|wdata (set), old&~wdata (clear), applied on the same edge; no update when modify[1:0]=00 or addr not selected.
REQ-015 SHALL drive rdata/valid combinationally from addr and current register state, independent of read.
REQ-016 SHALL run prescaler counter only while EN=1; tick asserted for one cycle when it equals PRESCALE, then it reloads 0 (tick every PRESCALE+1 cycles; PRESCALE=0 ticks every cycle).
REQ-017 SHALL hold prescaler counter at 0 while EN=0 and reset it to 0 on any software op to PRESCALE.
REQ-018 SHALL on tick with COUNT!=COMPARE increment COUNT modulo 2^32 (0xFFFFFFFF -> 0x00000000, no flag).
REQ-019 SHALL on tick with COUNT==COMPARE set PEND and load COUNT 0; if PERIODIC=0 also clear EN (one-shot).
REQ-020 SHALL register irq = PEND & IE, so irq rises exactly one cycle after the PEND-setting edge.
REQ-021 SHALL give hardware PEND set priority over a same-cycle software clear of PEND.
REQ-022 SHALL give software writes to COUNT priority over same-cycle tick increment/reload.
REQ-023 SHALL give software clearing EN priority over same-cycle one-shot logic; the tick still takes effect on COUNT/PEND unless REQ-022 applies.
REQ-024 SHALL keep irq high until PEND or IE is cleared by software; no edge-triggered pulse.
REQ-025 SHALL not alter any state on read strobe alone (reads have no side effects).

Reset
REQ-026 SHALL asynchronously on rstn=0 clear CTRL, PRESCALE, COUNT, prescaler counter and irq to 0, and set COMPARE to 0xFFFFFFFF.
REQ-027 SHALL with rstn=0 still drive rdata/valid from addr per REQ-015 (values reflect reset state).
REQ-028 SHALL after rstn release mid-count resume from reset values, no residual PEND or irq.

Verification
REQ-029 SHALL cover: PRESCALE=0, COMPARE=3, CTRL=0x7 -> COUNT 0,1,2,3 then PEND=1 and COUNT=0 on match edge, irq=1 next cycle, repeats every 4 cycles.
REQ-030 SHALL cover: PRESCALE=4, COMPARE=1, CTRL=0x3 (one-shot) -> match after 10 clk, EN reads 0, COUNT stays 0, irq=1 until clear CTRL bit3 -> irq=0 one cycle later.
REQ-031 SHALL cover: COUNT=0xFFFFFFFE, COMPARE=5, PRESCALE=0, EN=1 -> COUNT 0xFFFFFFFF, 0x00000000, ..., 5, PEND=1; no spurious PEND at wrap.
REQ-032 SHALL cover: software clear PEND in same cycle as match -> PEND reads 1; software write COUNT=0x100 in tick cycle -> COUNT reads 0x100.
REQ-033 SHALL cover: addr=BASE_ADDR+4 and addr=BASE_ADDR-1 with any modify -> valid=0, rdata=0, no register change.
REQ-034 SHALL cover: rstn pulsed low asynchronously (between edges) while irq=1 -> irq, CTRL, COUNT read 0, COMPARE reads 0xFFFFFFFF immediately.
